// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcode constants,
// sequencer state encoding and opcode classification helpers.
package alu_seq_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL5  = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV10 = 4'd3;
  localparam logic [OP_W-1:0] OP_INC   = 4'd4;
  localparam logic [OP_W-1:0] OP_DEC   = 4'd5;
  localparam logic [OP_W-1:0] OP_AND   = 4'd6;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd7;
  localparam logic [OP_W-1:0] OP_OR    = 4'd8;
  localparam logic [OP_W-1:0] OP_COMP  = 4'd9;
  localparam logic [OP_W-1:0] OP_LAST  = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } seq_state_t;

  // Only the arithmetic ops can meaningfully overflow; the ALU's ov pin is
  // don't-care for the logical/divide ops and must be masked off for them.
  function automatic logic op_has_ovf(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL5, OP_INC, OP_DEC:          return 1'b1;
      OP_DIV10, OP_AND, OP_XOR, OP_OR, OP_COMP:         return 1'b0;
      default:                                          return 1'b0;
    endcase
  endfunction

  // Opcodes above the last defined ALU operation are answered without
  // touching the ALU at all.
  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return (op > OP_LAST);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small synchronous FIFO holding packed {a, b, op} commands for the
// sequencer. Pointers carry one extra bit so full and empty can be told
// apart when the index bits match.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DW    = 36,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic          w_doPush;
  logic          w_doPop;

  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_rdata  = r_mem[r_rdPtr[AW-1:0]];

  // Advance the read/write pointers; reset discards every queued command.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PW'(1);
    end
  end

  // Storage array needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command-side initiator for the 16-bit combinational ALU. Commands are
// queued in a FIFO, issued to the ALU from registers, held for a settle
// interval, and the result is returned on a valid/ready response port.
// A saturating counter tracks accepted responses that reported overflow.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int OPW        = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 1,
  parameter int CNTW       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OPW-1:0]   cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ov,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_ov,
  output logic [OPW-1:0]   rsp_op,
  output logic             rsp_illegal,
  input  logic             ovf_clr,
  output logic [CNTW-1:0]  ovf_count
);

  localparam int DW  = 2 * WIDTH + OPW;
  localparam int SCW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  seq_state_t       r_state;
  seq_state_t       w_nextState;

  logic [WIDTH-1:0] r_aluA;
  logic [WIDTH-1:0] r_aluB;
  logic [OPW-1:0]   r_aluOp;
  logic [SCW-1:0]   r_settleCnt;

  logic             r_rspValid;
  logic [WIDTH-1:0] r_rspResult;
  logic             r_rspOv;
  logic [OPW-1:0]   r_rspOp;
  logic             r_rspIllegal;
  logic [CNTW-1:0]  r_ovfCount;

  logic             w_fifoFull;
  logic             w_fifoEmpty;
  logic             w_push;
  logic             w_pop;
  logic [DW-1:0]    w_fifoRdata;
  logic [WIDTH-1:0] w_headA;
  logic [WIDTH-1:0] w_headB;
  logic [OPW-1:0]   w_headOp;

  logic             w_loadIssue;
  logic             w_loadIllegal;
  logic             w_capture;
  logic             w_rspDone;
  logic             w_ovfCapture;

  // Ready is withheld during reset so nothing is accepted on the reset edge.
  assign cmd_ready = !w_fifoFull && !rst;
  assign w_push    = cmd_valid && cmd_ready;

  assign {w_headA, w_headB, w_headOp} = w_fifoRdata;

  alu_cmd_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({cmd_a, cmd_b, cmd_op}),
    .o_rdata (w_fifoRdata),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  assign w_ovfCapture = alu_ov && op_has_ovf(OP_W'(r_aluOp));

  // Next-state and per-cycle control strobes for the IDLE/ISSUE/RESP sequence.
  always_comb begin
    w_nextState   = r_state;
    w_pop         = 1'b0;
    w_loadIssue   = 1'b0;
    w_loadIllegal = 1'b0;
    w_capture     = 1'b0;
    w_rspDone     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifoEmpty) begin
          w_pop = 1'b1;
          if (op_is_illegal(OP_W'(w_headOp))) begin
            w_loadIllegal = 1'b1;
            w_nextState   = RESP;
          end else begin
            w_loadIssue = 1'b1;
            w_nextState = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (r_settleCnt == SCW'(1)) begin
          w_capture   = 1'b1;
          w_nextState = RESP;
        end
      end
      RESP: begin
        if (r_rspValid && rsp_ready) begin
          w_rspDone   = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // ALU operand registers only change on a legal pop; the settle counter
  // counts down while the ALU inputs are held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluOp     <= '0;
      r_settleCnt <= '0;
    end else if (w_loadIssue) begin
      r_aluA      <= w_headA;
      r_aluB      <= w_headB;
      r_aluOp     <= w_headOp;
      r_settleCnt <= SCW'(SETTLE);
    end else if (r_state == ISSUE) begin
      r_settleCnt <= r_settleCnt - SCW'(1);
    end
  end

  // Response registers: loaded from the ALU after settling or directly for an
  // illegal opcode, then held until the consumer takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rspValid   <= 1'b0;
      r_rspResult  <= '0;
      r_rspOv      <= 1'b0;
      r_rspOp      <= '0;
      r_rspIllegal <= 1'b0;
    end else if (w_loadIllegal) begin
      r_rspValid   <= 1'b1;
      r_rspResult  <= '0;
      r_rspOv      <= 1'b0;
      r_rspOp      <= w_headOp;
      r_rspIllegal <= 1'b1;
    end else if (w_capture) begin
      r_rspValid   <= 1'b1;
      r_rspResult  <= alu_result;
      r_rspOv      <= w_ovfCapture;
      r_rspOp      <= r_aluOp;
      r_rspIllegal <= 1'b0;
    end else if (w_rspDone) begin
      r_rspValid   <= 1'b0;
    end
  end

  // Overflow event counter: clear wins over a same-cycle increment, and the
  // count sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || ovf_clr) begin
      r_ovfCount <= '0;
    end else if (w_rspDone && r_rspOv && (r_ovfCount != '1)) begin
      r_ovfCount <= r_ovfCount + CNTW'(1);
    end
  end

  assign alu_a       = r_aluA;
  assign alu_b       = r_aluB;
  assign alu_op      = r_aluOp;
  assign rsp_valid   = r_rspValid;
  assign rsp_result  = r_rspResult;
  assign rsp_ov      = r_rspOv;
  assign rsp_op      = r_rspOp;
  assign rsp_illegal = r_rspIllegal;
  assign ovf_count   = r_ovfCount;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a behavioural ALU model.
module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [3:0]  cmd_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_ov;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_ov;
  logic [3:0]  rsp_op;
  logic        rsp_illegal;
  logic        ovf_clr;
  logic [7:0]  ovf_count;

  logic        forceOv;
  logic [16:0] sum17;

  int testsRun;
  int testsFailed;
  int cycleCnt;

  typedef struct {
    logic [15:0] result;
    int          cyc;
  } rsp_t;
  rsp_t rspQ[$];

  alu_sequencer #(
    .WIDTH      (16),
    .OPW        (4),
    .FIFO_DEPTH (4),
    .SETTLE     (1),
    .CNTW       (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_op      (cmd_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_ov      (alu_ov),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_ov      (rsp_ov),
    .rsp_op      (rsp_op),
    .rsp_illegal (rsp_illegal),
    .ovf_clr     (ovf_clr),
    .ovf_count   (ovf_count)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to timestamp accepted responses.
  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Behavioural ALU: opcode 0-9 functions, carry-out overflow on ADD, and a
  // forceOv input that drives ov high regardless of opcode.
  always_comb begin
    sum17      = {1'b0, alu_a} + {1'b0, alu_b};
    alu_result = '0;
    case (alu_op)
      4'd0: alu_result = sum17[15:0];
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = 16'(alu_a * 16'd5);
      4'd3: alu_result = alu_a / 16'd10;
      4'd4: alu_result = alu_a + 16'd1;
      4'd5: alu_result = alu_a - 16'd1;
      4'd6: alu_result = alu_a & alu_b;
      4'd7: alu_result = alu_a ^ alu_b;
      4'd8: alu_result = alu_a | alu_b;
      4'd9: alu_result = ~alu_a;
      default: alu_result = '0;
    endcase
    alu_ov = forceOv || ((alu_op == 4'd0) && sum17[16]);
  end

  // Response monitor: log every handshake with its cycle stamp.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rspQ.push_back('{result: rsp_result, cyc: cycleCnt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] op);
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitRsp(input string tag, input int maxCycles);
    for (int i = 0; i < maxCycles && !rsp_valid; i++) tick();
    checkOutput(tag, {31'd0, rsp_valid}, 32'd1);
  endtask

  logic [15:0] aList[6];
  logic [15:0] bList[6];
  logic [3:0]  opList[6];
  logic [15:0] expList[6];
  int          idx;
  logic        pushed;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_a       = '0;
    cmd_b       = '0;
    cmd_op      = '0;
    rsp_ready   = 1'b0;
    ovf_clr     = 1'b0;
    forceOv     = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_alu_a", {16'd0, alu_a}, 32'd0);
    checkOutput("rst_alu_op", {28'd0, alu_op}, 32'd0);
    checkOutput("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
    checkOutput("rst_ovf_count", {24'd0, ovf_count}, 32'd0);
    checkOutput("rst_cmd_ready_in_rst", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Single ADD 3+4: accept at E, pop at E+1, response after E+2
    applyStimulus(16'd3, 16'd4, 4'd0);
    tick();
    cmd_valid = 1'b0;
    checkOutput("add_valid_e0", {31'd0, rsp_valid}, 32'd0);
    tick();
    checkOutput("add_alu_a", {16'd0, alu_a}, 32'd3);
    checkOutput("add_alu_b", {16'd0, alu_b}, 32'd4);
    checkOutput("add_valid_e1", {31'd0, rsp_valid}, 32'd0);
    tick();
    checkOutput("add_valid_e2", {31'd0, rsp_valid}, 32'd1);
    checkOutput("add_result", {16'd0, rsp_result}, 32'd7);
    checkOutput("add_ov", {31'd0, rsp_ov}, 32'd0);
    checkOutput("add_illegal", {31'd0, rsp_illegal}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    checkOutput("add_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
    checkOutput("add_alu_op_held", {28'd0, alu_op}, 32'd0);
    checkOutput("add_alu_a_held", {16'd0, alu_a}, 32'd3);

    // Five back-to-back commands with rsp_ready=1
    aList   = '{16'd10, 16'd50, 16'd7,  16'd100, 16'h00F0, 16'd0};
    bList   = '{16'd20, 16'd8,  16'd0,  16'd0,   16'h0FF0, 16'd0};
    opList  = '{4'd0,   4'd1,   4'd2,   4'd3,    4'd6,     4'd0};
    expList = '{16'd30, 16'd42, 16'd35, 16'd10,  16'h00F0, 16'd0};
    rspQ.delete();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(aList[i], bList[i], opList[i]);
      checkOutput($sformatf("b2b_ready_%0d", i), {31'd0, cmd_ready}, 32'd1);
      tick();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 30 && rspQ.size() < 5; i++) tick();
    checkOutput("b2b_rsp_count", rspQ.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < rspQ.size()) begin
        checkOutput($sformatf("b2b_result_%0d", i), {16'd0, rspQ[i].result},
                    {16'd0, expList[i]});
        if (i > 0) begin
          checkOutput($sformatf("b2b_spacing_%0d", i),
                      rspQ[i].cyc - rspQ[i-1].cyc, 32'd3);
        end
      end
    end

    // Illegal opcode 12: answered one cycle after pop, ALU regs untouched
    rsp_ready = 1'b0;
    applyStimulus(16'd1, 16'd2, 4'd12);
    tick();
    cmd_valid = 1'b0;
    checkOutput("ill_valid_e0", {31'd0, rsp_valid}, 32'd0);
    tick();
    checkOutput("ill_valid_e1", {31'd0, rsp_valid}, 32'd1);
    checkOutput("ill_flag", {31'd0, rsp_illegal}, 32'd1);
    checkOutput("ill_result", {16'd0, rsp_result}, 32'd0);
    checkOutput("ill_op", {28'd0, rsp_op}, 32'd12);
    checkOutput("ill_alu_a_kept", {16'd0, alu_a}, 32'h00F0);
    checkOutput("ill_alu_b_kept", {16'd0, alu_b}, 32'h0FF0);
    checkOutput("ill_alu_op_kept", {28'd0, alu_op}, 32'd6);
    rsp_ready = 1'b1;
    tick();

    // Overflow masking: DIV10 with ov forced is masked, ADD is counted
    forceOv = 1'b1;
    applyStimulus(16'd100, 16'd0, 4'd3);
    tick();
    cmd_valid = 1'b0;
    waitRsp("div_timeout", 10);
    checkOutput("div_result", {16'd0, rsp_result}, 32'd10);
    checkOutput("div_ov_masked", {31'd0, rsp_ov}, 32'd0);
    tick();
    checkOutput("div_ovf_count", {24'd0, ovf_count}, 32'd0);
    applyStimulus(16'd1, 16'd1, 4'd0);
    tick();
    cmd_valid = 1'b0;
    waitRsp("addov_timeout", 10);
    checkOutput("addov_result", {16'd0, rsp_result}, 32'd2);
    checkOutput("addov_ov", {31'd0, rsp_ov}, 32'd1);
    tick();
    checkOutput("addov_ovf_count", {24'd0, ovf_count}, 32'd1);
    forceOv = 1'b0;

    // Back-pressure: hold rsp_ready low for 10 cycles while offering six commands
    aList   = '{16'd1, 16'd9, 16'd3, 16'd3, 16'hF0F0, 16'h1234};
    bList   = '{16'd1, 16'd4, 16'd0, 16'd0, 16'h0FF0, 16'd0};
    opList  = '{4'd0,  4'd1,  4'd4,  4'd5,  4'd7,     4'd9};
    expList = '{16'd2, 16'd5, 16'd4, 16'd2, 16'hFF00, 16'hEDCB};
    rspQ.delete();
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 6) applyStimulus(aList[idx], bList[idx], opList[idx]);
      else         cmd_valid = 1'b0;
      pushed = cmd_valid && cmd_ready;
      tick();
      if (pushed) idx++;
    end
    checkOutput("bp_pushed", idx, 32'd5);
    checkOutput("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    checkOutput("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("bp_rsp_result_held", {16'd0, rsp_result}, 32'd2);
    checkOutput("bp_rsp_op_held", {28'd0, rsp_op}, 32'd0);
    checkOutput("bp_alu_a_no_pop", {16'd0, alu_a}, 32'd1);
    checkOutput("bp_no_rsp", rspQ.size(), 32'd0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && (rspQ.size() < 6 || idx < 6); c++) begin
      if (idx < 6) applyStimulus(aList[idx], bList[idx], opList[idx]);
      else         cmd_valid = 1'b0;
      pushed = cmd_valid && cmd_ready;
      tick();
      if (pushed) idx++;
    end
    cmd_valid = 1'b0;
    checkOutput("bp_drain_count", rspQ.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < rspQ.size()) begin
        checkOutput($sformatf("bp_result_%0d", i), {16'd0, rspQ[i].result},
                    {16'd0, expList[i]});
      end
    end

    // Reset while in ISSUE with two commands queued
    rsp_ready = 1'b0;
    aList  = '{16'd11, 16'd22, 16'd33, 16'd44, 16'd0, 16'd0};
    opList = '{4'd0,   4'd4,   4'd4,   4'd4,   4'd0,  4'd0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(aList[i], 16'd1, opList[i]);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    tick();
    checkOutput("rstmid_in_issue_alu_a", {16'd0, alu_a}, 32'd22);
    checkOutput("rstmid_ovf_before", {24'd0, ovf_count}, 32'd1);
    rspQ.delete();
    rst = 1'b1;
    tick();
    checkOutput("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rstmid_alu_a", {16'd0, alu_a}, 32'd0);
    checkOutput("rstmid_alu_op", {28'd0, alu_op}, 32'd0);
    checkOutput("rstmid_rsp_result", {16'd0, rsp_result}, 32'd0);
    checkOutput("rstmid_ovf_count", {24'd0, ovf_count}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("rstmid_no_rsp", rspQ.size(), 32'd0);
    checkOutput("rstmid_valid_after", {31'd0, rsp_valid}, 32'd0);

    // ovf_clr beats a simultaneous counted handshake
    forceOv   = 1'b1;
    rsp_ready = 1'b0;
    applyStimulus(16'd1, 16'd1, 4'd0);
    tick();
    cmd_valid = 1'b0;
    waitRsp("clr_timeout", 10);
    checkOutput("clr_rsp_ov", {31'd0, rsp_ov}, 32'd1);
    rsp_ready = 1'b1;
    ovf_clr   = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("clr_priority", {24'd0, ovf_count}, 32'd0);
    applyStimulus(16'd2, 16'd2, 4'd0);
    tick();
    cmd_valid = 1'b0;
    waitRsp("inc_timeout", 10);
    tick();
    checkOutput("inc_after_clr", {24'd0, ovf_count}, 32'd1);

    // Saturation: 260 more overflowing responses from a count of 1
    rspQ.delete();
    idx = 0;
    for (int c = 0; c < 2000 && (idx < 260 || rspQ.size() < 260); c++) begin
      if (idx < 260) applyStimulus(16'd1, 16'd1, 4'd0);
      else           cmd_valid = 1'b0;
      pushed = cmd_valid && cmd_ready;
      tick();
      if (pushed) idx++;
    end
    cmd_valid = 1'b0;
    forceOv   = 1'b0;
    checkOutput("sat_rsp_count", rspQ.size(), 32'd260);
    checkOutput("sat_ovf_count", {24'd0, ovf_count}, 32'd255);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
